// File: rtl/sid_cycle_sequencer.sv
// Per-sample cycle schedule for the shared dual-SID voice/filter/DCA pipeline.
// One tick launches a CYCLES-long run; model changes are deferred to idle.
module sid_cycle_sequencer #(
    parameter int CYCLES      = 20,
    parameter int VOICE_START = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] model_in,
    input  logic       model_we,
    input  logic       ovr_clr,
    output logic [4:0] cycle,
    output logic [1:0] model,
    output logic       voice_valid,
    output logic [2:0] voice_slot,
    output logic       sid_sel,
    output logic       done,
    output logic       busy,
    output logic       overrun
);

    localparam logic [4:0] LAST_CYCLE  = 5'(CYCLES - 1);
    localparam logic [4:0] VOICE_FIRST = 5'(VOICE_START);
    localparam logic [4:0] VOICE_LAST  = 5'(VOICE_START + 5);

    logic [4:0] cycle_reg;
    logic [1:0] model_reg;
    logic [1:0] model_pend_reg;
    logic       model_dirty_reg;
    logic       pending_reg;
    logic       done_reg;
    logic       overrun_reg;

    logic idle;
    logic start;
    logic tick_lost;

    assign idle      = (cycle_reg == 5'd0);
    assign start     = idle && (tick || pending_reg);
    assign tick_lost = !idle && tick && pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_reg       <= 5'd0;
            model_reg       <= 2'b00;
            model_pend_reg  <= 2'b00;
            model_dirty_reg <= 1'b0;
            pending_reg     <= 1'b0;
            done_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (idle) begin
                if (start) begin
                    cycle_reg   <= 5'd1;
                    pending_reg <= 1'b0;
                end
                // Idle writes land immediately, so a same-edge start sees them.
                if (model_we) begin
                    model_reg <= model_in;
                end
            end else begin
                if (tick && !pending_reg) begin
                    pending_reg <= 1'b1;
                end
                if (cycle_reg == LAST_CYCLE) begin
                    cycle_reg       <= 5'd0;
                    done_reg        <= 1'b1;
                    model_dirty_reg <= 1'b0;
                    if (model_we) begin
                        model_reg <= model_in;
                    end else if (model_dirty_reg) begin
                        model_reg <= model_pend_reg;
                    end
                end else begin
                    cycle_reg <= cycle_reg + 5'd1;
                    if (model_we) begin
                        model_pend_reg  <= model_in;
                        model_dirty_reg <= 1'b1;
                    end
                end
            end
            // A lost tick outranks a clear on the same edge.
            if (tick_lost) begin
                overrun_reg <= 1'b1;
            end else if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign cycle       = cycle_reg;
    assign model       = model_reg;
    assign done        = done_reg;
    assign overrun     = overrun_reg;
    assign busy        = !idle;
    assign voice_valid = (cycle_reg >= VOICE_FIRST) && (cycle_reg <= VOICE_LAST);
    assign voice_slot  = voice_valid ? 3'(cycle_reg - VOICE_FIRST) : 3'd0;
    assign sid_sel     = voice_valid && (voice_slot >= 3'd3);

endmodule

// File: tb/tb_sid_cycle_sequencer.sv
// Bench for sid_cycle_sequencer: three parameterisations share one stimulus and
// are each compared every cycle against a start-time based reference model.
module tb_sid_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] model_in = 2'b00;
    logic       model_we = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [4:0] cyc [3];
    logic [1:0] mdl [3];
    logic       vv [3];
    logic [2:0] vs [3];
    logic       ss [3];
    logic       dn [3];
    logic       bz [3];
    logic       ov [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int C  = (gi == 0) ? 20 : (gi == 1) ? 14 : 31;
        localparam int VS = (gi == 2) ? 20 : 6;

        sid_cycle_sequencer #(.CYCLES(C), .VOICE_START(VS)) dut (
            .clk(clk), .rst_n(rst_n), .tick(tick), .model_in(model_in),
            .model_we(model_we), .ovr_clr(ovr_clr), .cycle(cyc[gi]), .model(mdl[gi]),
            .voice_valid(vv[gi]), .voice_slot(vs[gi]), .sid_sel(ss[gi]),
            .done(dn[gi]), .busy(bz[gi]), .overrun(ov[gi])
        );

        // Reference: a run is described by the edge index it started on; the
        // cycle number is simply the number of edges elapsed since then.
        int         n_edge = 0;
        int         start_edge = -1;
        bit         m_pend = 0;
        bit         m_ovr = 0;
        bit         m_done = 0;
        logic [1:0] m_model = 2'b00;
        logic [1:0] m_req = 2'b00;
        bit         m_req_valid = 0;

        function automatic int m_cycle();
            return (start_edge < 0) ? 0 : n_edge - start_edge;
        endfunction

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    n_edge = 0; start_edge = -1; m_pend = 0; m_ovr = 0;
                    m_done = 0; m_model = 2'b00; m_req = 2'b00; m_req_valid = 0;
                end else begin
                    int  c;
                    bit  lost;
                    c = m_cycle();
                    lost = (c != 0) && tick && m_pend;
                    n_edge++;
                    m_done = 0;
                    if (c == 0) begin
                        if (tick || m_pend) begin
                            start_edge = n_edge - 1;
                            m_pend = 0;
                        end
                        if (model_we) m_model = model_in;
                    end else begin
                        if (tick) m_pend = 1;
                        if (model_we) begin
                            m_req = model_in;
                            m_req_valid = 1;
                        end
                        if (c == C - 1) begin
                            start_edge = -1;
                            m_done = 1;
                            if (m_req_valid) m_model = m_req;
                            m_req_valid = 0;
                        end
                    end
                    if (lost) m_ovr = 1;
                    else if (ovr_clr) m_ovr = 0;
                end
            end
        end

        initial begin
            forever begin
                int  c;
                bit  in_win;
                @(negedge clk);
                c = m_cycle();
                in_win = (c >= VS) && (c < VS + 6);
                chk("cycle", gi, 32'(cyc[gi]), 32'(c));
                chk("model", gi, 32'(mdl[gi]), 32'(m_model));
                chk("done", gi, 32'(dn[gi]), 32'(m_done));
                chk("busy", gi, 32'(bz[gi]), 32'(c != 0));
                chk("overrun", gi, 32'(ov[gi]), 32'(m_ovr));
                chk("voice_valid", gi, 32'(vv[gi]), 32'(in_win));
                chk("voice_slot", gi, 32'(vs[gi]), in_win ? 32'(c - VS) : 32'd0);
                chk("sid_sel", gi, 32'(ss[gi]), in_win ? 32'((c - VS) / 3) : 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_c0(input int v);
        for (int i = 0; i < 100; i++) begin
            step();
            if (cyc[0] == 5'(v)) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_cycle: cycle never reached %0d, last %0d", v, cyc[0]);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        $display("reset: cycle=%0d model=%0d done=%0d", cyc[0], mdl[0], dn[0]);
        chk("rst_cycle", 0, 32'(cyc[0]), 32'd0);
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        rst_n = 1'b1;
        repeat (5) step();

        // Basic run and voice window
        pulse_tick();
        chk("start_latency", 0, 32'(cyc[0]), 32'd1);
        repeat (18) step();
        chk("last_cycle", 0, 32'(cyc[0]), 32'd19);
        step();
        chk("wrap_cycle", 0, 32'(cyc[0]), 32'd0);
        chk("wrap_done", 0, 32'(dn[0]), 32'd1);
        chk("wrap_busy", 0, 32'(bz[0]), 32'd0);
        step();
        chk("done_width", 0, 32'(dn[0]), 32'd0);
        $display("basic run: wrapped to 0 with done pulse");
        pulse_tick();
        wait_c0(9);
        chk("slot_at_9", 0, 32'(vs[0]), 32'd3);
        chk("sid_at_9", 0, 32'(ss[0]), 32'd1);
        wait_c0(12);
        chk("valid_at_12", 0, 32'(vv[0]), 32'd0);
        wait_c0(0);
        step();
        $display("voice window: slot/sid probed at cycles 9 and 12");

        // Pending and overrun
        pulse_tick();
        wait_c0(5);
        pulse_tick();
        wait_c0(8);
        pulse_tick();
        chk("overrun_set", 0, 32'(ov[0]), 32'd1);
        wait_c0(0);
        step();
        chk("pending_launch", 0, 32'(cyc[0]), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("overrun_clr", 0, 32'(ov[0]), 32'd0);
        wait_c0(3);
        pulse_tick();
        wait_c0(6);
        pulse_tick();
        wait_c0(8);
        ovr_clr = 1'b1;
        pulse_tick();
        ovr_clr = 1'b0;
        chk("overrun_set_wins", 0, 32'(ov[0]), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("overrun_clr2", 0, 32'(ov[0]), 32'd0);
        wait_c0(0);
        step();
        wait_c0(0);
        repeat (40) step();
        $display("pending/overrun: second run launched, overrun set/clear exercised");

        // Model deferral
        pulse_tick();
        wait_c0(4);
        model_in = 2'b10; model_we = 1'b1;
        step();
        model_we = 1'b0;
        chk("model_held_a", 0, 32'(mdl[0]), 32'd0);
        wait_c0(9);
        model_in = 2'b01; model_we = 1'b1;
        step();
        model_we = 1'b0;
        chk("model_held_b", 0, 32'(mdl[0]), 32'd0);
        wait_c0(0);
        chk("model_applied", 0, 32'(mdl[0]), 32'd1);
        step();
        model_in = 2'b11; model_we = 1'b1;
        pulse_tick();
        model_we = 1'b0;
        chk("model_same_edge", 0, 32'(mdl[0]), 32'd3);
        chk("model_same_cycle", 0, 32'(cyc[0]), 32'd1);
        wait_c0(0);
        repeat (40) step();
        $display("model deferral: last write 01 applied at wrap, idle write 11 at start");

        // Asynchronous reset mid-run
        pulse_tick();
        wait_c0(5);
        pulse_tick();
        wait_c0(12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cycle", 0, 32'(cyc[0]), 32'd0);
        chk("async_model", 0, 32'(mdl[0]), 32'd0);
        chk("async_done", 0, 32'(dn[0]), 32'd0);
        chk("async_valid", 0, 32'(vv[0]), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (25) step();
        chk("no_restart", 0, 32'(cyc[0]), 32'd0);
        pulse_tick();
        chk("clean_start", 0, 32'(cyc[0]), 32'd1);
        wait_c0(0);
        chk("clean_done", 0, 32'(dn[0]), 32'd1);
        repeat (40) step();
        $display("async reset: outputs cleared without clock, clean restart");

        // Parameter sweep: C=14 and C=31/VS=20 instances
        pulse_tick();
        repeat (12) step();
        chk("c14_last", 1, 32'(cyc[1]), 32'd13);
        step();
        chk("c14_wrap", 1, 32'(cyc[1]), 32'd0);
        chk("c14_done", 1, 32'(dn[1]), 32'd1);
        repeat (9) step();
        chk("c31_slot", 2, 32'(vs[2]), 32'd3);
        chk("c31_sid", 2, 32'(ss[2]), 32'd1);
        repeat (7) step();
        chk("c31_last", 2, 32'(cyc[2]), 32'd30);
        step();
        chk("c31_wrap", 2, 32'(cyc[2]), 32'd0);
        chk("c31_done", 2, 32'(dn[2]), 32'd1);
        repeat (3) step();
        $display("parameter sweep: wraps at 13 and 30 observed");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
